// File: rtl/dma_channel.sv
`default_nettype none
// ============================================================================
// Module   : dma_channel
// Brief    : Single GBA-style DMA channel; bus master doing read/write copies.
// Revision : 1.0
// ============================================================================
module dma_channel #(
  parameter int          COUNT_WIDTH = 14,
  parameter logic [31:0] SRC_MASK    = 32'h0FFFFFFF,
  parameter logic [31:0] DST_MASK    = 32'h07FFFFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            cfg_src,
  input  logic [31:0]            cfg_dst,
  input  logic [COUNT_WIDTH-1:0] cfg_count,
  input  logic                   cfg_word,
  input  logic [1:0]             cfg_src_ctl,
  input  logic [1:0]             cfg_dst_ctl,
  input  logic                   cfg_irq_en,
  output logic                   bus_req,
  input  logic                   bus_grant,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic [1:0]             mem_width,
  output logic                   mem_read,
  output logic                   mem_write,
  input  logic                   mem_ok,
  output logic                   busy,
  output logic                   irq
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_WR      = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Counter is one bit wider so a zero count can hold 2^COUNT_WIDTH.
  localparam logic [COUNT_WIDTH:0] c_full = {1'b1, {COUNT_WIDTH{1'b0}}};
  localparam logic [COUNT_WIDTH:0] c_one  = {{COUNT_WIDTH{1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_next;
  logic [31:0]            r_src;
  logic [31:0]            r_dst;
  logic [31:0]            r_data;
  logic [COUNT_WIDTH:0]   r_count;
  logic                   r_word;
  logic [1:0]             r_src_ctl;
  logic [1:0]             r_dst_ctl;
  logic                   r_irq_en;
  logic                   r_wr_first;
  logic                   w_wr_done;
  logic                   w_last;
  logic [1:0]             w_width;
  logic [31:0]            w_align;

  function automatic logic [31:0] f_step(input logic [31:0] a, input logic [1:0] ctl,
                                         input logic word);
    logic [31:0] d;
    d = word ? 32'd4 : 32'd2;
    case (ctl)
      2'd1:    return a - d;
      2'd2:    return a;
      default: return a + d;
    endcase
  endfunction

  assign w_align   = cfg_word ? 32'hFFFF_FFFC : 32'hFFFF_FFFE;
  assign w_width   = r_word ? 2'd2 : 2'd1;
  // The first WR cycle never completes, which covers both aligned and RMW memories.
  assign w_wr_done = (r_state == S_WR) && mem_ok && !r_wr_first;
  assign w_last    = (r_count == c_one);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_data     <= '0;
      r_count    <= '0;
      r_word     <= 1'b0;
      r_src_ctl  <= 2'd0;
      r_dst_ctl  <= 2'd0;
      r_irq_en   <= 1'b0;
      r_wr_first <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_src     <= cfg_src & SRC_MASK & w_align;
        r_dst     <= cfg_dst & DST_MASK & w_align;
        r_count   <= (cfg_count == '0) ? c_full : {1'b0, cfg_count};
        r_word    <= cfg_word;
        r_src_ctl <= cfg_src_ctl;
        r_dst_ctl <= cfg_dst_ctl;
        r_irq_en  <= cfg_irq_en;
      end
      if (r_state == S_RD_DATA && mem_ok) begin
        r_data     <= r_word ? mem_rdata : {16'h0000, mem_rdata[15:0]};
        r_wr_first <= 1'b1;
      end
      if (r_state == S_WR) begin
        r_wr_first <= 1'b0;
      end
      if (w_wr_done) begin
        r_src   <= f_step(r_src, r_src_ctl, r_word);
        r_dst   <= f_step(r_dst, r_dst_ctl, r_word);
        r_count <= r_count - c_one;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    bus_req   = 1'b0;
    busy      = (r_state != S_IDLE);
    irq       = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_width = 2'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_REQ;
      end
      S_REQ: begin
        bus_req = 1'b1;
        if (bus_grant) w_next = S_RD_ADDR;
      end
      S_RD_ADDR: begin
        bus_req   = 1'b1;
        mem_addr  = r_src;
        mem_read  = 1'b1;
        mem_width = w_width;
        w_next    = S_RD_DATA;
      end
      S_RD_DATA: begin
        bus_req   = 1'b1;
        mem_addr  = r_src;
        mem_read  = 1'b1;
        mem_width = w_width;
        if (mem_ok) w_next = S_WR;
      end
      S_WR: begin
        bus_req   = 1'b1;
        mem_addr  = r_dst;
        mem_wdata = r_data;
        mem_write = 1'b1;
        mem_width = w_width;
        if (w_wr_done) w_next = w_last ? S_DONE : S_RD_ADDR;
      end
      S_DONE: begin
        irq    = r_irq_en;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_channel.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_channel
// Brief    : Table-driven scoreboard bench for dma_channel.
// Revision : 1.0
// ============================================================================
module tb_dma_channel;

  localparam int          CW    = 4;
  localparam logic [31:0] SMASK = 32'h0FFFFFFF;
  localparam logic [31:0] DMASK = 32'h07FFFFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   cfg_src = '0;
  logic [31:0]   cfg_dst = '0;
  logic [CW-1:0] cfg_count = '0;
  logic          cfg_word = 1'b0;
  logic [1:0]    cfg_src_ctl = 2'd0;
  logic [1:0]    cfg_dst_ctl = 2'd0;
  logic          cfg_irq_en = 1'b0;
  logic          bus_req;
  logic          bus_grant = 1'b1;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [1:0]    mem_width;
  logic          mem_read;
  logic          mem_write;
  logic          mem_ok;
  logic          busy;
  logic          irq;

  always #5 clk = ~clk;

  dma_channel #(.COUNT_WIDTH(CW), .SRC_MASK(SMASK), .DST_MASK(DMASK)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_count(cfg_count), .cfg_word(cfg_word),
    .cfg_src_ctl(cfg_src_ctl), .cfg_dst_ctl(cfg_dst_ctl), .cfg_irq_en(cfg_irq_en),
    .bus_req(bus_req), .bus_grant(bus_grant),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_width(mem_width),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ok(mem_ok),
    .busy(busy), .irq(irq)
  );

  typedef struct {
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [31:0] wdata;
    logic [1:0]  width;
  } exp_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [3:0]  count;
    logic        word;
    logic [1:0]  sctl;
    logic [1:0]  dctl;
    logic        irq_en;
    int          stall;
    int          rmw;
    int          gdelay;
    logic        restart;
  } xfer_t;

  exp_t  exp_q[$];
  xfer_t tbl[7];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int irq_cnt = 0;
  int irq_rel = 0;
  int wr_starts = 0;
  int rd_cyc = 0;
  int wr_cyc = 0;
  int rd_len = 0;
  int wr_len = 0;
  int cur_rd_stall = 0;
  int cur_rmw = 0;
  logic aborting = 1'b0;
  logic prev_read = 1'b0;
  logic prev_write = 1'b0;
  logic [31:0] cur_raddr = '0;
  logic [31:0] cur_waddr = '0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A96};
  endfunction

  // Memory model: garbage on stalled cycles so an early latch is visible.
  assign mem_rdata = mem_ok ? mem_f(mem_addr) : 32'hDEADBEEF;

  always_comb begin
    mem_ok = 1'b1;
    if (mem_read) mem_ok = (rd_cyc == 0) || (rd_cyc > cur_rd_stall);
    else if (mem_write && cur_rmw != 0) mem_ok = (wr_cyc != 1);
  end

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_cyc <= mem_read ? rd_cyc + 1 : 0;
    wr_cyc <= mem_write ? wr_cyc + 1 : 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (irq) begin
      irq_cnt <= irq_cnt + 1;
      irq_rel <= cyc - start_cyc + 1;
    end
    if (!rst && !aborting) begin
      chk("rw_excl", {31'b0, mem_read & mem_write}, 32'h0);
      if (!mem_read && !mem_write) chk("addr_idle", {mem_addr[31:2], mem_addr[1:0] | mem_width}, 32'h0);
      if (mem_read && !prev_read) begin
        chk("sb_has_rd", {31'b0, exp_q.size() > 0}, 32'h1);
        if (exp_q.size() > 0) begin
          chk("rd_addr", mem_addr, exp_q[0].rd_addr);
          chk("rd_width", {30'b0, mem_width}, {30'b0, exp_q[0].width});
        end
        cur_raddr <= mem_addr;
      end
      if (mem_read && prev_read) chk("rd_hold", mem_addr, cur_raddr);
      if (!mem_read && prev_read) chk("rd_len", rd_len, 2 + cur_rd_stall);
      if (mem_write && !prev_write) begin
        wr_starts <= wr_starts + 1;
        chk("sb_has_wr", {31'b0, exp_q.size() > 0}, 32'h1);
        if (exp_q.size() > 0) begin
          chk("wr_addr", mem_addr, exp_q[0].wr_addr);
          chk("wr_data", mem_wdata, exp_q[0].wdata);
          chk("wr_width", {30'b0, mem_width}, {30'b0, exp_q[0].width});
          exp_q.pop_front();
        end
        cur_waddr <= mem_addr;
      end
      if (mem_write && prev_write) chk("wr_hold", mem_addr, cur_waddr);
      if (!mem_write && prev_write) chk("wr_len", wr_len, 2 + cur_rmw);
    end
    prev_read  <= mem_read;
    prev_write <= mem_write;
    rd_len     <= mem_read ? rd_len + 1 : 0;
    wr_len     <= mem_write ? wr_len + 1 : 0;
  end

  task automatic push_expect(input xfer_t t, output int n);
    logic [31:0] s, d, rv, inc;
    n   = (t.count == 4'd0) ? (1 << CW) : int'(t.count);
    s   = t.src & SMASK;
    d   = t.dst & DMASK;
    inc = t.word ? 32'd4 : 32'd2;
    if (t.word) begin s[1:0] = 2'b00; d[1:0] = 2'b00; end
    else begin s[0] = 1'b0; d[0] = 1'b0; end
    for (int i = 0; i < n; i++) begin
      rv = mem_f(s);
      if (!t.word) rv[31:16] = 16'h0000;
      exp_q.push_back('{s, d, rv, t.word ? 2'd2 : 2'd1});
      if (t.sctl == 2'd1) s = s - inc; else if (t.sctl != 2'd2) s = s + inc;
      if (t.dctl == 2'd1) d = d - inc; else if (t.dctl != 2'd2) d = d + inc;
    end
  endtask

  task automatic issue_start(input xfer_t t);
    @(negedge clk);
    cfg_src = t.src; cfg_dst = t.dst; cfg_count = t.count; cfg_word = t.word;
    cfg_src_ctl = t.sctl; cfg_dst_ctl = t.dctl; cfg_irq_en = t.irq_en;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic run_xfer(input xfer_t t);
    int n, irq0;
    bit done;
    cur_rd_stall = t.stall;
    cur_rmw      = t.rmw;
    bus_grant    = (t.gdelay == 0);
    push_expect(t, n);
    issue_start(t);
    irq0 = irq_cnt;
    for (int i = 0; i < t.gdelay; i++) begin
      @(negedge clk); #1;
      chk("req_wait", {30'b0, bus_req, mem_read}, 32'h2);
    end
    if (t.gdelay > 0) begin
      @(negedge clk);
      bus_grant = 1'b1;
    end
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk); #1;
      // A second start carrying different config must be ignored.
      if (t.restart && k == 6) begin
        cfg_src = 32'h0BADBAD0; cfg_dst = 32'h01234560; cfg_count = 4'd1;
        cfg_word = ~t.word; cfg_irq_en = ~t.irq_en; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (!busy) done = 1'b1;
    end
    start = 1'b0;
    chk("timeout", {31'b0, done}, 32'h1);
    chk("q_empty", exp_q.size(), 32'h0);
    chk("irq_count", irq_cnt - irq0, {31'b0, t.irq_en});
    if (t.irq_en) chk("irq_cycle", irq_rel, 2 + t.gdelay + n * (4 + t.stall + t.rmw));
    chk("idle_outs", {27'b0, bus_req, mem_read, mem_write, irq, busy}, 32'h0);
    exp_q.delete();
  endtask

  initial begin
    int irq0, ws0, n;
    bit found;
    //           src           dst           cnt word sctl dctl irq stall rmw gdly restart
    tbl[0] = '{32'h03000000, 32'h02000000, 4'd4, 1'b1, 2'd0, 2'd0, 1'b1, 0, 0, 0, 1'b0};
    tbl[1] = '{32'h03000107, 32'h05000010, 4'd3, 1'b0, 2'd1, 2'd2, 1'b1, 0, 0, 0, 1'b0};
    tbl[2] = '{32'h03000000, 32'h02000100, 4'd0, 1'b1, 2'd3, 2'd3, 1'b0, 0, 0, 0, 1'b0};
    tbl[3] = '{32'h03000010, 32'h02000020, 4'd2, 1'b1, 2'd0, 2'd0, 1'b1, 3, 1, 0, 1'b0};
    tbl[4] = '{32'h03000020, 32'h02000040, 4'd3, 1'b0, 2'd0, 2'd0, 1'b1, 0, 0, 5, 1'b1};
    tbl[5] = '{32'hF3000003, 32'hFA000006, 4'd2, 1'b1, 2'd0, 2'd1, 1'b1, 0, 0, 0, 1'b0};
    tbl[6] = '{32'h00000003, 32'h02000001, 4'd3, 1'b0, 2'd1, 2'd1, 1'b1, 0, 0, 0, 1'b0};

    @(negedge clk); #1;
    chk("rst_outs", {27'b0, bus_req, mem_read, mem_write, irq, busy}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_width", {30'b0, mem_width}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_xfer(tbl[i]);

    // Abort in the first WR cycle of unit 2, then confirm a clean restart.
    cur_rd_stall = 0;
    cur_rmw      = 0;
    bus_grant    = 1'b1;
    push_expect(tbl[0], n);
    ws0 = wr_starts;
    issue_start(tbl[0]);
    irq0 = irq_cnt;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk); #1;
      if (wr_starts == ws0 + 2 && mem_write) found = 1'b1;
    end
    chk("abort_reach", {31'b0, found}, 32'h1);
    aborting = 1'b1;
    rst = 1'b1;
    #1;
    chk("abort_outs", {29'b0, mem_write, bus_req, busy}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    chk("abort_irq", irq_cnt - irq0, 32'h0);
    chk("abort_idle", {30'b0, busy, bus_req}, 32'h0);
    aborting = 1'b0;
    run_xfer(tbl[0]);
    run_xfer(tbl[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
